// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared opcodes, widths and entry type for the ALU execute stage
package alu_exec_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef enum logic [3:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_XOR   = 4'b0010,
      OP_ADD   = 4'b0011,
      OP_EQ    = 4'b0101,
      OP_NE    = 4'b0110,
      OP_LT    = 4'b0111,
      OP_GE    = 4'b1000,
      OP_PASSB = 4'b1100
   } alu_op_e;

   // One stored pipeline entry; result is sized for the widest supported datapath.
   typedef struct packed {
      logic [DATA_WIDTH_DEFAULT-1:0] result;
      logic                          cond;
      logic [4:0]                    rd;
   } exec_entry_t;

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - upstream/downstream handshake bundle of the ALU execute stage
interface alu_exec_if #(
   parameter int DATA_WIDTH = alu_exec_pkg::DATA_WIDTH_DEFAULT
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_op;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;
   logic [4:0]            in_rd;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_result;
   logic                  out_cond;
   logic                  out_zero;
   logic [4:0]            out_rd;

   // Driven by whoever feeds the stage and sinks its results.
   modport master (
      output in_valid, in_op, in_a, in_b, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_cond, out_zero, out_rd
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_cond, out_zero, out_rd
   );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: op/a/b to result and branch condition
module alu_core
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic [3:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  cond_o
);

   always_comb begin
      result_o = '0;
      cond_o   = 1'b0;
      case (op_i)
         OP_AND:   result_o = a_i & b_i;
         OP_OR:    result_o = a_i | b_i;
         OP_XOR:   result_o = a_i ^ b_i;
         OP_ADD:   result_o = a_i + b_i;
         OP_PASSB: result_o = b_i;
         // Compares report the flag both in cond and as a 0/1 result.
         OP_EQ: begin
            cond_o      = (a_i == b_i);
            result_o[0] = cond_o;
         end
         OP_NE: begin
            cond_o      = (a_i != b_i);
            result_o[0] = cond_o;
         end
         OP_LT: begin
            cond_o      = ($signed(a_i) < $signed(b_i));
            result_o[0] = cond_o;
         end
         OP_GE: begin
            cond_o      = ($signed(a_i) >= $signed(b_i));
            result_o[0] = cond_o;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered execute stage with valid/ready output and flush
// Optional feature: ALU_EXEC_SKID_EN adds a skid register and a registered in_ready.
module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   alu_exec_if.slave bus
);

   logic [DATA_WIDTH-1:0] core_result;
   logic                  core_cond;
   exec_entry_t           new_entry;

   exec_entry_t out_q, out_d;
   logic        out_valid_q, out_valid_d;
   logic        in_ready;
   logic        accept;
   logic        consume;

   alu_core #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_core (
      .op_i    (bus.in_op),
      .a_i     (bus.in_a),
      .b_i     (bus.in_b),
      .result_o(core_result),
      .cond_o  (core_cond)
   );

   always_comb begin
      new_entry        = '0;
      new_entry.result = DATA_WIDTH_DEFAULT'(core_result);
      new_entry.cond   = core_cond;
      new_entry.rd     = bus.in_rd;
   end

   assign accept  = bus.in_valid && in_ready && !flush;
   assign consume = out_valid_q && bus.out_ready;

`ifdef ALU_EXEC_SKID_EN

   exec_entry_t skid_q, skid_d;
   logic        skid_valid_q, skid_valid_d;
   logic        in_ready_q;

   assign in_ready = in_ready_q;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // in_ready is low here, so only the skid-to-output move can happen.
         if (consume) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q || consume) begin
            out_d       = new_entry;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
         end
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

`else

   assign in_ready = !out_valid_q || bus.out_ready;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_d       = new_entry;
         out_valid_d = 1'b1;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

`endif

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_q.result[DATA_WIDTH-1:0];
   assign bus.out_cond   = out_q.cond;
   assign bus.out_zero   = (out_q.result[DATA_WIDTH-1:0] == '0);
   assign bus.out_rd     = out_q.rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   alu_exec_if #(.DATA_WIDTH(32)) bus ();

   alu_exec_stage #(.DATA_WIDTH(32)) dut (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .bus  (bus)
   );

`ifdef ALU_EXEC_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   typedef struct {
      logic [31:0] result;
      logic        cond;
      logic [4:0]  rd;
   } exp_t;

   exp_t model_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   accepted = 0;

   function automatic exp_t ref_exec(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] rd);
      exp_t e;
      int   sa;
      int   sb;
      sa = a;
      sb = b;
      e.rd     = rd;
      e.cond   = 1'b0;
      e.result = 32'd0;
      case (op)
         4'd0:  e.result = a & b;
         4'd1:  e.result = a | b;
         4'd2:  e.result = a ^ b;
         4'd3:  e.result = a + b;
         4'd5:  e.cond = (a == b);
         4'd6:  e.cond = (a != b);
         4'd7:  e.cond = (sa < sb);
         4'd8:  e.cond = (sa >= sb);
         4'd12: e.result = b;
         default: ;
      endcase
      if (op >= 4'd5 && op <= 4'd8) e.result = e.cond ? 32'd1 : 32'd0;
      return e;
   endfunction

   // Called at posedge+1: drive, check before the next edge, then advance the model.
   task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic ordy,
                       input logic fl, input string tag);
      logic exp_rdy;
      bit   acc;
      bit   con;
      exp_t e;
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_rd     = rd;
      bus.out_ready = ordy;
      flush         = fl;
      #3;
      if (DEPTH == 2) exp_rdy = (model_q.size() < 2);
      else            exp_rdy = (model_q.size() == 0) || ordy;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s in_ready got %0b want %0b", tag, bus.in_ready, exp_rdy);
      end
      checks++;
      if (bus.out_valid !== (model_q.size() != 0)) begin
         errors++;
         $display("FAIL %s out_valid got %0b want %0b", tag, bus.out_valid, model_q.size() != 0);
      end
      if (model_q.size() != 0) begin
         e = model_q[0];
         checks++;
         if (bus.out_result !== e.result || bus.out_cond !== e.cond ||
             bus.out_zero !== (e.result == 32'd0) || bus.out_rd !== e.rd) begin
            errors++;
            $display("FAIL %s entry got res=%h cond=%0b zero=%0b rd=%0d want res=%h cond=%0b zero=%0b rd=%0d",
                     tag, bus.out_result, bus.out_cond, bus.out_zero, bus.out_rd,
                     e.result, e.cond, e.result == 32'd0, e.rd);
         end
      end
      acc = v && exp_rdy && !fl;
      con = (model_q.size() != 0) && ordy;
      if (con) void'(model_q.pop_front());
      if (fl) model_q.delete();
      if (acc) begin
         model_q.push_back(ref_exec(op, a, b, rd));
         accepted++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, ordy, 1'b0, "idle");
   endtask

   task automatic test_reset();
      reset = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_a = 32'd0; bus.in_b = 32'd0;
      bus.in_rd = 5'd0; bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_result !== 32'd0 || bus.out_cond !== 1'b0 ||
          bus.out_zero !== 1'b1 || bus.out_rd !== 5'd0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset got v=%0b res=%h cond=%0b zero=%0b rd=%0d rdy=%0b want 0/0/0/1/0/1",
                  bus.out_valid, bus.out_result, bus.out_cond, bus.out_zero, bus.out_rd, bus.in_ready);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_q.delete();
   endtask

   task automatic test_add();
      step(1'b1, 4'b0011, 32'd5, 32'd7, 5'd9, 1'b1, 1'b0, "add");
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 || bus.out_zero !== 1'b0 ||
          bus.out_cond !== 1'b0 || bus.out_rd !== 5'd9) begin
         errors++;
         $display("FAIL add_5_7 got v=%0b res=%0d zero=%0b cond=%0b rd=%0d want 1/12/0/0/9",
                  bus.out_valid, bus.out_result, bus.out_zero, bus.out_cond, bus.out_rd);
      end
      idle(1, 1'b1);
   endtask

   task automatic test_compare();
      step(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0, "lt");
      checks++;
      if (bus.out_result !== 32'd1 || bus.out_cond !== 1'b1) begin
         errors++;
         $display("FAIL lt_neg1_1 got res=%h cond=%0b want 1/1", bus.out_result, bus.out_cond);
      end
      step(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 1'b0, "ge");
      checks++;
      if (bus.out_result !== 32'd0 || bus.out_cond !== 1'b0 || bus.out_zero !== 1'b1) begin
         errors++;
         $display("FAIL ge_neg1_1 got res=%h cond=%0b zero=%0b want 0/0/1",
                  bus.out_result, bus.out_cond, bus.out_zero);
      end
      idle(1, 1'b1);
   endtask

   task automatic test_lui_undef();
      step(1'b1, 4'b1100, 32'hDEAD_BEEF, 32'h1234_5000, 5'd7, 1'b1, 1'b0, "lui");
      checks++;
      if (bus.out_result !== 32'h1234_5000 || bus.out_cond !== 1'b0) begin
         errors++;
         $display("FAIL lui got res=%h cond=%0b want 12345000/0", bus.out_result, bus.out_cond);
      end
      step(1'b1, 4'b1111, 32'h5, 32'h5, 5'd8, 1'b1, 1'b0, "undef");
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.out_cond !== 1'b0) begin
         errors++;
         $display("FAIL undef got v=%0b res=%h cond=%0b want 1/0/0",
                  bus.out_valid, bus.out_result, bus.out_cond);
      end
      idle(1, 1'b1);
   endtask

   task automatic test_back_to_back();
      int start;
      start = accepted;
      for (int i = 0; i < 8; i++)
         step(1'b1, 4'b0011, $urandom, $urandom, 5'(i + 1), 1'b1, 1'b0, "b2b");
      checks++;
      if (accepted - start !== 8) begin
         errors++;
         $display("FAIL b2b_count got %0d want 8", accepted - start);
      end
      idle(1, 1'b1);
   endtask

   task automatic test_stall();
      int start;
      start = accepted;
      for (int i = 0; i < 3; i++)
         step(1'b1, 4'b0011, $urandom, $urandom, 5'(20 + i), 1'b0, 1'b0, "stall");
      checks++;
      if (accepted - start !== DEPTH) begin
         errors++;
         $display("FAIL stall_accepts got %0d want %0d", accepted - start, DEPTH);
      end
      idle(3, 1'b1);
   endtask

   task automatic test_flush();
      step(1'b1, 4'b0010, $urandom, $urandom, 5'd11, 1'b0, 1'b0, "fill");
      step(1'b1, 4'b0001, $urandom, $urandom, 5'd12, 1'b0, 1'b0, "fill");
      step(1'b1, 4'b0011, 32'd1, 32'd1, 5'd13, 1'b0, 1'b1, "flush");
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_valid got %0b want 0", bus.out_valid);
      end
      idle(3, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom, 5'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rand");
      idle(3, 1'b1);
   endtask

   task automatic test_reset_mid_stall();
      step(1'b1, 4'b0011, $urandom, $urandom, 5'd30, 1'b0, 1'b0, "pre_rst");
      step(1'b1, 4'b0011, $urandom, $urandom, 5'd31, 1'b0, 1'b0, "pre_rst");
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got v=%0b rdy=%0b want 0/1", bus.out_valid, bus.in_ready);
      end
      model_q.delete();
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(3, 1'b0);
      step(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 1'b1, 1'b0, "post_rst");
      idle(2, 1'b1);
   endtask

   initial begin
      test_reset();
      test_add();
      test_compare();
      test_lui_undef();
      test_back_to_back();
      test_stall();
      test_flush();
      test_random();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
